// File: rtl/linear_interp.sv
// Linear interpolating upsampler: each accepted sample closes a segment of 2^INTERP_POW points.
// Latency: point 0 of a segment is valid the cycle after the closing sample is accepted.
// Backpressure: output holds while ready_out=0; input is taken only at segment end or when idle.
module linear_interp #(
    parameter int DATA_WIDTH = 10,
    parameter int INTERP_POW = 7
) (
    input  logic                  clock,
    input  logic                  sclr_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_out
);

    localparam int ACC_W = DATA_WIDTH + INTERP_POW + 1;
    localparam logic [INTERP_POW-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        EMPTY,
        PRIMED,
        RUN
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_prev;
    logic signed [DATA_WIDTH:0] r_step;
    logic [ACC_W-1:0]        r_acc;
    logic [INTERP_POW-1:0]   r_cnt;
    logic                    r_valid;

    logic                    w_last;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_out_xfer;
    logic signed [DATA_WIDTH:0] w_new_step;
    logic [ACC_W-1:0]        w_step_ext;

    assign w_last     = (r_cnt == CNT_LAST);
    assign ready_in   = sclr_n && ((r_state != RUN) || (ready_out && w_last));
    assign w_accept   = valid_in && ready_in;
    // From PRIMED, or gaplessly at the last point of a running segment.
    assign w_load     = w_accept && (r_state != EMPTY);
    assign w_out_xfer = r_valid && ready_out;
    assign w_new_step = $signed({1'b0, data_in}) - $signed({1'b0, r_prev});
    assign w_step_ext = {{INTERP_POW{r_step[DATA_WIDTH]}}, r_step};

    assign data_out  = r_acc[DATA_WIDTH+INTERP_POW-1:INTERP_POW];
    assign valid_out = r_valid;

    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            r_state <= EMPTY;
            r_prev  <= '0;
            r_step  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_step <= w_new_step;
                r_acc  <= {1'b0, r_prev, {INTERP_POW{1'b0}}};
                r_prev <= data_in;
                r_cnt  <= '0;
            end else if (w_out_xfer) begin
                r_acc <= r_acc + w_step_ext;
                r_cnt <= r_cnt + 1'b1;
            end

            unique case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_prev  <= data_in;
                        r_state <= PRIMED;
                    end
                end
                PRIMED: begin
                    if (w_accept) begin
                        r_state <= RUN;
                        r_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_out_xfer && w_last && !w_accept) begin
                        r_state <= PRIMED;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_linear_interp.sv
// Randomised and directed bench for linear_interp at INTERP_POW = 7, 2 and 12.
module tb_linear_interp;

    localparam int DW = 10;
    localparam int NU = 3;

    logic          clock;
    logic          sclr_n    [NU];
    logic [DW-1:0] data_in   [NU];
    logic          valid_in  [NU];
    logic          ready_in  [NU];
    logic [DW-1:0] data_out  [NU];
    logic          valid_out [NU];
    logic          ready_out [NU];

    int errors = 0;
    int checks = 0;

    int stim[$];
    int exp_q[$];
    int q_out[$];
    int q_vld[$];
    int q_rdy[$];
    int q_acc[$];
    int q_dat[$];
    int stall_bad;
    bit timed_out;

    linear_interp #(.DATA_WIDTH(DW), .INTERP_POW(7)) u_p7 (
        .clock(clock), .sclr_n(sclr_n[0]), .data_in(data_in[0]), .valid_in(valid_in[0]),
        .ready_in(ready_in[0]), .data_out(data_out[0]), .valid_out(valid_out[0]),
        .ready_out(ready_out[0]));

    linear_interp #(.DATA_WIDTH(DW), .INTERP_POW(2)) u_p2 (
        .clock(clock), .sclr_n(sclr_n[1]), .data_in(data_in[1]), .valid_in(valid_in[1]),
        .ready_in(ready_in[1]), .data_out(data_out[1]), .valid_out(valid_out[1]),
        .ready_out(ready_out[1]));

    linear_interp #(.DATA_WIDTH(DW), .INTERP_POW(12)) u_p12 (
        .clock(clock), .sclr_n(sclr_n[2]), .data_in(data_in[2]), .valid_in(valid_in[2]),
        .ready_in(ready_in[2]), .data_out(data_out[2]), .valid_out(valid_out[2]),
        .ready_out(ready_out[2]));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Point i of segment a->b is floor(a + i*(b-a)/N) = floor((a*(N-i) + i*b)/N), never negative.
    function automatic int interp_pt(input int a, input int b, input int i, input int pw);
        int n;
        n = 1 << pw;
        return (a * (n - i) + i * b) / n;
    endfunction

    task automatic build_exp(input int pw);
        exp_q.delete();
        for (int k = 1; k < stim.size(); k++)
            for (int i = 0; i < (1 << pw); i++)
                exp_q.push_back(interp_pt(stim[k-1], stim[k], i, pw));
    endtask

    task automatic reset_unit(input int u);
        sclr_n[u]    = 1'b0;
        valid_in[u]  = 1'b0;
        ready_out[u] = 1'b1;
        @(posedge clock);
        #1;
        sclr_n[u] = 1'b1;
    endtask

    // Offers stim in order and collects output transfers; records per-cycle traces. No checking here.
    task automatic run(input int u, input int bp_pct, input int n_out, input int limit);
        int idx;
        int cyc;
        bit hold;
        int hold_val;
        idx = 0; cyc = 0; hold = 0; hold_val = 0;
        q_out.delete(); q_vld.delete(); q_rdy.delete(); q_acc.delete(); q_dat.delete();
        stall_bad = 0;
        while ((idx < stim.size() || q_out.size() < n_out) && cyc < limit) begin
            if (idx < stim.size()) begin
                valid_in[u] = 1'b1;
                data_in[u]  = DW'(stim[idx]);
            end else begin
                valid_in[u] = 1'b0;
            end
            ready_out[u] = (int'($urandom_range(99)) >= bp_pct);
            @(negedge clock);
            q_vld.push_back(int'(valid_out[u]));
            q_rdy.push_back(int'(ready_in[u]));
            q_dat.push_back(int'(data_out[u]));
            if (hold && (valid_out[u] !== 1'b1 || int'(data_out[u]) != hold_val)) stall_bad++;
            hold     = valid_out[u] && !ready_out[u];
            hold_val = int'(data_out[u]);
            if (valid_out[u] && ready_out[u]) q_out.push_back(int'(data_out[u]));
            q_acc.push_back(int'(valid_in[u] && ready_in[u]));
            if (valid_in[u] && ready_in[u]) idx++;
            @(posedge clock);
            #1;
            cyc++;
        end
        valid_in[u]  = 1'b0;
        ready_out[u] = 1'b1;
        timed_out    = (cyc >= limit);
    endtask

    task automatic test_reset;
        for (int u = 0; u < NU; u++) begin
            sclr_n[u] = 1'b0; valid_in[u] = 1'b1; data_in[u] = 10'd77; ready_out[u] = 1'b1;
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int u = 0; u < NU; u++) begin
            checks++;
            if (valid_out[u] !== 1'b0) begin errors++; $display("FAIL reset_valid u%0d: got %b want 0", u, valid_out[u]); end
            checks++;
            if (data_out[u] !== '0) begin errors++; $display("FAIL reset_data u%0d: got %0d want 0", u, data_out[u]); end
            checks++;
            if (ready_in[u] !== 1'b0) begin errors++; $display("FAIL reset_ready_low u%0d: got %b want 0", u, ready_in[u]); end
        end
        @(posedge clock);
        #1;
        for (int u = 0; u < NU; u++) begin sclr_n[u] = 1'b1; valid_in[u] = 1'b0; end
        @(negedge clock);
        for (int u = 0; u < NU; u++) begin
            checks++;
            if (ready_in[u] !== 1'b1) begin errors++; $display("FAIL reset_ready_empty u%0d: got %b want 1", u, ready_in[u]); end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_ramp;
        int j;
        int bad;
        reset_unit(0);
        stim = '{0, 128};
        run(0, 0, 128, 1000);
        checks++;
        if (timed_out || q_out.size() != 128) begin
            errors++; $display("FAIL ramp_count: got %0d outputs (timeout=%0d) want 128", q_out.size(), timed_out);
        end
        bad = 0;
        for (int i = 0; i < q_out.size(); i++) if (q_out[i] != i) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL ramp_values: %0d wrong points want 0..127", bad); end
        j = -1;
        for (int c = 0; c < q_acc.size(); c++) if (q_acc[c] == 1) j = c;
        bad = 0;
        for (int c = 0; c < q_vld.size(); c++) if (q_vld[c] != ((c > j && c <= j + 128) ? 1 : 0)) bad++;
        checks++;
        if (j < 0 || bad != 0) begin
            errors++; $display("FAIL ramp_timing: second accept cycle %0d, %0d cycles with wrong valid_out", j, bad);
        end
        @(negedge clock);
        checks++;
        if (valid_out[0] !== 1'b0) begin errors++; $display("FAIL ramp_end_valid: got %b want 0", valid_out[0]); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_neg_step_and_floor;
        int e1[4];
        int e2[4];
        e1 = '{100, 75, 50, 25};
        e2 = '{0, 0, 1, 2};
        reset_unit(1);
        stim = '{100, 0};
        run(1, 0, 4, 100);
        checks++;
        if (q_out.size() != 4) begin errors++; $display("FAIL neg_count: got %0d want 4", q_out.size()); end
        for (int i = 0; i < 4 && i < q_out.size(); i++) begin
            checks++;
            if (q_out[i] != e1[i]) begin errors++; $display("FAIL neg_step[%0d]: got %0d want %0d", i, q_out[i], e1[i]); end
        end
        reset_unit(1);
        stim = '{0, 3};
        run(1, 0, 4, 100);
        checks++;
        if (q_out.size() != 4) begin errors++; $display("FAIL floor_count: got %0d want 4", q_out.size()); end
        for (int i = 0; i < 4 && i < q_out.size(); i++) begin
            checks++;
            if (q_out[i] != e2[i]) begin errors++; $display("FAIL floor[%0d]: got %0d want %0d", i, q_out[i], e2[i]); end
        end
    endtask

    task automatic test_back_to_back;
        int first;
        int last;
        int nv;
        int bad_rdy;
        int bad_val;
        reset_unit(1);
        stim = '{0, 4, 8};
        run(1, 0, 8, 100);
        bad_val = 0;
        for (int i = 0; i < q_out.size(); i++) if (q_out[i] != i) bad_val++;
        checks++;
        if (q_out.size() != 8 || bad_val != 0) begin
            errors++; $display("FAIL b2b_values: got %0d outputs, %0d wrong, want 0..7", q_out.size(), bad_val);
        end
        first = -1; last = -1; nv = 0; bad_rdy = 0;
        for (int c = 0; c < q_vld.size(); c++) begin
            if (q_vld[c] == 1) begin
                if (first < 0) first = c;
                last = c;
                nv++;
                if (q_rdy[c] != ((q_dat[c] == 3 || q_dat[c] == 7) ? 1 : 0)) bad_rdy++;
            end
        end
        checks++;
        if (nv != 8 || last - first != 7) begin
            errors++; $display("FAIL b2b_gapless: %0d valid cycles spanning %0d want 8 spanning 8", nv, last - first + 1);
        end
        checks++;
        if (bad_rdy != 0) begin errors++; $display("FAIL b2b_ready_pulse: %0d cycles wrong want 0", bad_rdy); end
    endtask

    task automatic test_backpressure;
        int bad;
        reset_unit(0);
        stim = '{0, 1023};
        run(0, 50, 128, 5000);
        bad = 0;
        for (int i = 0; i < q_out.size(); i++) if (q_out[i] != (i * 1023) / 128) bad++;
        checks++;
        if (timed_out || q_out.size() != 128 || bad != 0) begin
            errors++; $display("FAIL bp_seq: got %0d outputs, %0d wrong, want 128 exact", q_out.size(), bad);
        end
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL bp_stable: %0d unstable stalls want 0", stall_bad); end
        for (int u = 0; u < 2; u++) begin
            reset_unit(u);
            stim.delete();
            for (int k = 0; k < (u == 0 ? 3 : 9); k++) stim.push_back(int'($urandom_range(1023)));
            build_exp(u == 0 ? 7 : 2);
            run(u, 35, exp_q.size(), 4000);
            bad = 0;
            for (int i = 0; i < q_out.size() && i < exp_q.size(); i++) if (q_out[i] != exp_q[i]) bad++;
            checks++;
            if (timed_out || q_out.size() != exp_q.size() || bad != 0) begin
                errors++; $display("FAIL rand_seq u%0d: got %0d outputs, %0d wrong, want %0d", u, q_out.size(), bad, exp_q.size());
            end
            checks++;
            if (stall_bad != 0) begin errors++; $display("FAIL rand_stable u%0d: %0d unstable stalls want 0", u, stall_bad); end
        end
    endtask

    task automatic test_full_scale;
        int bad;
        reset_unit(2);
        stim = '{1023, 0, 1023};
        build_exp(12);
        run(2, 0, 8192, 20000);
        bad = 0;
        for (int i = 0; i < q_out.size() && i < exp_q.size(); i++) if (q_out[i] != exp_q[i]) bad++;
        checks++;
        if (timed_out || q_out.size() != 8192 || bad != 0) begin
            errors++; $display("FAIL full_seq: got %0d outputs, %0d wrong, want 8192", q_out.size(), bad);
        end
        if (q_out.size() == 8192) begin
            checks++;
            if (q_out[4095] != 0) begin errors++; $display("FAIL full_down_last: got %0d want 0", q_out[4095]); end
            checks++;
            if (q_out[8191] != 1022) begin errors++; $display("FAIL full_up_last: got %0d want 1022", q_out[8191]); end
            checks++;
            if (q_out[0] != 1023) begin errors++; $display("FAIL full_first: got %0d want 1023", q_out[0]); end
        end
    endtask

    task automatic test_mid_reset;
        int bad;
        reset_unit(0);
        stim = '{0, 128};
        run(0, 0, 10, 200);
        checks++;
        if (q_out.size() != 10 || q_out[9] != 9) begin errors++; $display("FAIL midrst_pre: got %0d outputs want 10 ending at 9", q_out.size()); end
        sclr_n[0] = 1'b0;
        @(negedge clock);
        checks++;
        if (ready_in[0] !== 1'b0) begin errors++; $display("FAIL midrst_ready_during: got %b want 0", ready_in[0]); end
        @(posedge clock);
        #1;
        sclr_n[0] = 1'b1;
        @(negedge clock);
        checks++;
        if (valid_out[0] !== 1'b0 || data_out[0] !== '0 || ready_in[0] !== 1'b1) begin
            errors++; $display("FAIL midrst_after: valid=%b data=%0d ready=%b want 0 0 1", valid_out[0], data_out[0], ready_in[0]);
        end
        @(posedge clock);
        #1;
        stim = '{50, 60};
        build_exp(7);
        run(0, 0, 128, 1000);
        bad = 0;
        for (int i = 0; i < q_out.size() && i < exp_q.size(); i++) if (q_out[i] != exp_q[i]) bad++;
        checks++;
        if (timed_out || q_out.size() != 128 || bad != 0 || q_out[0] != 50) begin
            errors++; $display("FAIL midrst_fresh: got %0d outputs, %0d wrong, want 128 starting at 50", q_out.size(), bad);
        end
    endtask

    initial begin
        for (int u = 0; u < NU; u++) begin
            sclr_n[u] = 1'b0; valid_in[u] = 1'b0; data_in[u] = '0; ready_out[u] = 1'b0;
        end
        test_reset();
        test_ramp();
        test_neg_step_and_floor();
        test_back_to_back();
        test_backpressure();
        test_full_scale();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
